// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one single-beat AXI3 master.
// One outstanding op per SRAM port; data reads win AR arbitration over inst reads.
module sram_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic {W_IDLE, W_SEND} w_state_t;

  ar_state_t   ar_state_q;
  w_state_t    w_state_q;
  logic        arvalid_q, awvalid_q, wvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [2:0]  arsize_q, awsize_q;
  logic [3:0]  wstrb_q;
  logic        inst_pend_q, data_pend_q, data_pend_wr_q;
  logic        rready_q, bready_q;
  logic        inst_data_ok_q, data_data_ok_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic data_rd_req, ar_idle, w_idle;
  logic inst_ok, data_rd_ok, data_wr_ok;
  logic r_hs, b_hs, r_inst, r_data, b_data;
  logic unused_ok;

  assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bresp};

  assign ar_idle     = (ar_state_q == AR_IDLE);
  assign w_idle      = (w_state_q == W_IDLE);
  assign data_rd_req = data_sram_req & ~data_sram_wr & ~data_pend_q;
  assign data_rd_ok  = ~reset & data_rd_req & ar_idle;
  assign data_wr_ok  = ~reset & data_sram_req & data_sram_wr & ~data_pend_q & w_idle;
  assign inst_ok     = ~reset & inst_sram_req & ~inst_sram_wr & ~inst_pend_q & ar_idle & ~data_rd_req;

  // Responses only count when they match an op we actually have in flight.
  assign r_hs   = rvalid & rready_q;
  assign b_hs   = bvalid & bready_q;
  assign r_inst = r_hs & (rid == ID_INST) & inst_pend_q;
  assign r_data = r_hs & (rid == ID_DATA) & data_pend_q & ~data_pend_wr_q;
  assign b_data = b_hs & (bid == ID_DATA) & data_pend_q & data_pend_wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state_q <= AR_IDLE;
      arvalid_q  <= 1'b0;
      arid_q     <= 4'd0;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
    end else begin
      case (ar_state_q)
        AR_IDLE: begin
          if (data_rd_ok) begin
            arid_q     <= ID_DATA;
            araddr_q   <= data_sram_addr;
            arsize_q   <= {1'b0, data_sram_size};
            arvalid_q  <= 1'b1;
            ar_state_q <= AR_SEND;
          end else if (inst_ok) begin
            arid_q     <= ID_INST;
            araddr_q   <= inst_sram_addr;
            arsize_q   <= {1'b0, inst_sram_size};
            arvalid_q  <= 1'b1;
            ar_state_q <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (arready) begin
            arvalid_q  <= 1'b0;
            ar_state_q <= AR_IDLE;
          end
        end
        default: ar_state_q <= AR_IDLE;
      endcase
    end
  end

  // AW and W complete independently; the write slot frees once both are done.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= 32'd0;
      awsize_q  <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (data_wr_ok) begin
            awaddr_q  <= data_sram_addr;
            awsize_q  <= {1'b0, data_sram_size};
            wdata_q   <= data_sram_wdata;
            wstrb_q   <= data_sram_wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state_q <= W_SEND;
          end
        end
        W_SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((~awvalid_q | awready) & (~wvalid_q | wready)) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_pend_q    <= 1'b0;
      data_pend_q    <= 1'b0;
      data_pend_wr_q <= 1'b0;
      rready_q       <= 1'b0;
      bready_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      rready_q <= 1'b1;
      bready_q <= 1'b1;
      if (inst_ok)     inst_pend_q <= 1'b1;
      else if (r_inst) inst_pend_q <= 1'b0;
      if (data_rd_ok | data_wr_ok) begin
        data_pend_q    <= 1'b1;
        data_pend_wr_q <= data_wr_ok;
      end else if (r_data | b_data) begin
        data_pend_q    <= 1'b0;
      end
      inst_data_ok_q <= r_inst;
      data_data_ok_q <= r_data | b_data;
      if (r_inst) inst_rdata_q <= rdata;
      if (r_data) data_rdata_q <= rdata;
    end
  end

  assign inst_sram_addr_ok = inst_ok;
  assign data_sram_addr_ok = data_rd_ok | data_wr_ok;
  assign inst_sram_data_ok = inst_data_ok_q;
  assign data_sram_data_ok = data_data_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = rready_q;

  assign awid    = ID_DATA;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid    = ID_DATA;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = bready_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: stimulus pushes expected AXI requests and
// SRAM responses into queues, a negedge monitor pops and compares them.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [38:0] exp_ar[$];    // {id, addr, size}
  logic [38:0] exp_aw[$];
  logic [40:0] exp_w[$];     // {id, data, strb, last}
  logic [31:0] exp_inst[$];  // inst_sram_rdata at data_ok
  logic [31:0] exp_data[$];  // data_sram_rdata at data_ok (held value for writes)

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_r(input logic [3:0] id, input logic [31:0] d);
    if (id == 4'd0) exp_inst.push_back(d);
    else exp_data.push_back(d);
    rvalid = 1'b1; rid = id; rdata = d;
    tick();
    rvalid = 1'b0;
  endtask

  // Monitor: one scoreboard pop per observed handshake / data_ok.
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ar_unexpected: got id=%0h addr=%0h, expected none", arid, araddr);
        end else chk("ar_req", {25'd0, arid, araddr, arsize}, {25'd0, exp_ar.pop_front()});
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL aw_unexpected: got addr=%0h, expected none", awaddr);
        end else chk("aw_req", {25'd0, awid, awaddr, awsize}, {25'd0, exp_aw.pop_front()});
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL w_unexpected: got data=%0h, expected none", wdata);
        end else chk("w_beat", {23'd0, wid, wdata, wstrb, wlast}, {23'd0, exp_w.pop_front()});
      end
      if (inst_sram_data_ok) begin
        if (exp_inst.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL inst_data_ok_unexpected: got rdata=%0h, expected no pulse", inst_sram_rdata);
        end else chk("inst_rdata", {32'd0, inst_sram_rdata}, {32'd0, exp_inst.pop_front()});
      end
      if (data_sram_data_ok) begin
        if (exp_data.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL data_data_ok_unexpected: got rdata=%0h, expected no pulse", data_sram_rdata);
        end else chk("data_rdata", {32'd0, data_sram_rdata}, {32'd0, exp_data.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; awready = 0; wready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    bid = 0; bresp = 0; bvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
    chk("rst_oks", {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rst_readies", {rready, bready}, 0);
    reset = 1'b0;
    tick();
    chk("readies_up", {rready, bready}, 2'b11);
    chk("ar_consts", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    chk("aw_consts", {awlen, awburst, awlock, awcache, awprot, wlast}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});

    // Single inst read, R three cycles after the AR handshake.
    inst_sram_req = 1; inst_sram_addr = 32'h1c000000; arready = 1;
    #1 chk("inst_addr_ok", inst_sram_addr_ok, 1);
    exp_ar.push_back({4'd0, 32'h1c000000, 3'd2});
    tick(); inst_sram_req = 0;
    tick();
    chk("arvalid_dropped", arvalid, 0);
    tick(); tick(); arready = 0;
    do_r(4'd0, 32'h02800c0c);
    tick(); tick();

    // inst_sram_wr is never accepted.
    inst_sram_req = 1; inst_sram_wr = 1;
    #1 chk("inst_wr_rejected", inst_sram_addr_ok, 0);
    tick(); inst_sram_req = 0; inst_sram_wr = 0;

    // Same-cycle inst/data reads: data wins, inst waits for AR idle.
    inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c008000;
    #1 chk("arb_data_ok", data_sram_addr_ok, 1);
    chk("arb_inst_wait", inst_sram_addr_ok, 0);
    exp_ar.push_back({4'd1, 32'h1c008000, 3'd2});
    tick(); data_sram_req = 0;
    #1 chk("inst_wait_busy", inst_sram_addr_ok, 0);
    tick();
    chk("arvalid_held", {arvalid, araddr}, {1'b1, 32'h1c008000});
    arready = 1;
    tick();
    #1 chk("inst_granted_after", inst_sram_addr_ok, 1);
    exp_ar.push_back({4'd0, 32'h1c000004, 3'd2});
    tick(); inst_sram_req = 0;
    tick(); arready = 0;
    // Data R returns before inst R.
    do_r(4'd1, 32'h11223344);
    do_r(4'd0, 32'h02801234);
    tick(); tick();

    // Write with awready two cycles before wready, then a read blocked behind it.
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c008010;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'hdeadbeef;
    #1 chk("wr_addr_ok", data_sram_addr_ok, 1);
    exp_aw.push_back({4'd1, 32'h1c008010, 3'd2});
    exp_w.push_back({4'd1, 32'hdeadbeef, 4'hf, 1'b1});
    tick(); data_sram_req = 0; awready = 1;
    chk("aw_w_rise", {awvalid, wvalid}, 2'b11);
    tick(); awready = 0;
    chk("aw_drop_w_hold", {awvalid, wvalid}, 2'b01);
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c008020;
    #1 chk("rd_blocked_1", data_sram_addr_ok, 0);
    tick();
    chk("rd_blocked_2", data_sram_addr_ok, 0);
    wready = 1;
    tick(); wready = 0;
    chk("w_drop", {awvalid, wvalid}, 2'b00);
    chk("rd_blocked_3", data_sram_addr_ok, 0);
    tick();
    bvalid = 1; bid = 4'd1;
    exp_data.push_back(32'h11223344);
    #1 chk("rd_blocked_bhs", data_sram_addr_ok, 0);
    tick(); bvalid = 0;
    #1 chk("rd_after_b", data_sram_addr_ok, 1);
    exp_ar.push_back({4'd1, 32'h1c008020, 3'd2});
    arready = 1;
    tick(); data_sram_req = 0;
    tick(); arready = 0;
    do_r(4'd1, 32'hcafef00d);
    tick(); tick();

    // Reset with arvalid high and an unacked write in flight.
    inst_sram_req = 1; inst_sram_addr = 32'h1c000100;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c008100; data_sram_wdata = 32'h12345678;
    #1 chk("pre_rst_grants", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b11);
    tick(); inst_sram_req = 0; data_sram_req = 0;
    chk("pre_rst_valids", {arvalid, awvalid, wvalid}, 3'b111);
    reset = 1;
    tick();
    chk("mid_rst_valids", {arvalid, awvalid, wvalid}, 0);
    reset = 0;
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1c000200;
    #1 chk("post_rst_accept", inst_sram_addr_ok, 1);
    exp_ar.push_back({4'd0, 32'h1c000200, 3'd2});
    arready = 1;
    tick(); inst_sram_req = 0;
    tick(); arready = 0;
    do_r(4'd0, 32'habcd0001);
    tick(); tick(); tick();

    chk("ar_queue_drained", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
    chk("resp_queue_drained", exp_inst.size() + exp_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
